multicycle_cu: RTL and testbench
================================

Name: multicycle_cu

Overview:
- Multi-cycle successor to the single-cycle RV32I control unit: an FSM that sequences fetch, decode, execute, memory and writeback over several cycles against a shared instruction/data memory with a ready handshake.
- Sits between the instruction register and the multi-cycle datapath (PC, IR, OldPC, A/B, ALUOut, Data registers).
- Adds sequential behaviour the combinational unit lacks:
  - per-state datapath enables;
  - memory wait-states with a timeout;
  - a pipeline-freeze input;
  - sticky illegal-instruction and bus-error traps.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles to wait for mem_ready before trapping; 0 disables the timeout.
- TO_W, $clog2(MEM_TIMEOUT+1), width of the wait counter (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- Zero, Less, LessU  in  1 each  ALU flags from rs1-rs2
- mem_ready  in  1  memory completes the current access this cycle
- stall  in  1  freeze FSM
- PCWrite, IRWrite, OldPCWrite, RegWrite, MemWrite, mem_req  out  1 each  enables
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = const 4
- ALUctrl  out  4  ALU operation
- ImmSrc  out  3  000 = I, 001 = I-shamt/unsigned, 010 = S, 011 = B, 100 = U, 101 = J
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- PCMaskLSB  out  1  clear PC[0] on write (JALR)
- funct3_o  out  3  funct3 passthrough for the load/store unit
- illegal, bus_err  out  1 each  sticky trap flags
- state_o  out  4  current state, for debug

Behaviour:
- Reset (rst high at a clk edge):
  - state → FETCH; wait counter → 0; illegal, bus_err, jalr_flag → 0.
  - All enables are Moore/Mealy outputs of FETCH: mem_req = 1, every write enable 0 until mem_ready.
  - Reset takes effect mid-access; any pending memory transaction is abandoned.
- Default outputs in every state: all enables 0, ALUctrl = 1111, ImmSrc = 000, muxes 00. funct3_o always equals funct3.
- ALUctrl encoding:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1001, SLTU 1010.
  - R-type: funct7_5 = 1 selects SUB (funct3 000) or SRA (funct3 101). I-type shifts use the same rule; SRAI also decodes to 0111.
- States and transitions (one state per cycle unless waiting):
  - FETCH: AdrSrc = 0, mem_req = 1. Wait while !mem_ready. On mem_ready: IRWrite, OldPCWrite, PCWrite with A = PC, B = 4, ADD, ResultSrc = 10 → DECODE.
  - DECODE: A = OldPC, B = imm, ADD (branch/JAL target into ALUOut); ImmSrc from op.
    - load/store → MEMADR; R → EXECR; I-ALU → EXECI; JAL → JAL; JALR → JALRADR; LUI → LUI; AUIPC → AUIPC; B → BRANCH.
    - Any other op, or an undefined funct3 for B/load/store → TRAP with illegal set.
  - MEMADR: A = rs1, B = imm, ADD; ImmSrc 010 for stores, 000 for loads → MEMRD (load) or MEMWR (store).
  - MEMRD: AdrSrc = 1, mem_req held until mem_ready → MEMWB.
  - MEMWB: ResultSrc = 01, RegWrite → FETCH.
  - MEMWR: AdrSrc = 1, mem_req and MemWrite held until mem_ready → FETCH.
  - EXECR: A = rs1, B = rs2, decoded ALUctrl → ALUWB.
  - EXECI: A = rs1, B = imm, decoded ALUctrl → ALUWB.
  - LUI: A = zero, B = imm, ImmSrc 100, ADD → ALUWB.
  - AUIPC: A = OldPC, B = imm, ImmSrc 100, ADD → ALUWB.
  - ALUWB: ResultSrc = 00, RegWrite → FETCH.
  - JALRADR: A = rs1, B = imm, ADD; set jalr_flag → JAL.
  - JAL: PCWrite with ResultSrc = 00 (target); A = OldPC, B = 4, ADD into ALUOut; PCMaskLSB = jalr_flag; clear jalr_flag → ALUWB.
  - BRANCH: A = rs1, B = rs2, SUB, ResultSrc = 00. PCWrite = {BEQ: Zero, BNE: ~Zero, BLT: Less, BGE: ~Less, BLTU: LessU, BGEU: ~LessU} → FETCH.
  - TRAP: all enables 0; remains until rst.
- Wait counter:
  - Counts cycles in FETCH/MEMRD/MEMWR with mem_ready low; clears on state exit.
  - If MEM_TIMEOUT > 0 and the counter reaches MEM_TIMEOUT with mem_ready still low: bus_err is set → TRAP.
  - mem_ready in the same cycle as the limit wins (no trap).
- stall:
  - State and counter hold; all write enables and MemWrite are forced 0.
  - mem_req and the mux selects are unchanged.
  - stall overrides mem_ready (the access is retried).
  - rst overrides stall.

Decomposition:
- Package cu_pkg: state_t enum; ALUctrl, ImmSrc, ALUSrcA/B and ResultSrc localparams; opcode constants.
- Sub-module alu_decoder (combinational: op class, funct3, funct7_5 → ALUctrl, ImmSrc, illegal_funct) — reusable by the single-cycle core.

Test Plan:
- rst; ADD x3,x1,x2 (funct7_5 = 0), mem_ready high → states FETCH, DECODE, EXECR, ALUWB, FETCH; ALUctrl = 0000 in EXECR; RegWrite only in ALUWB; SUB variant gives 0001.
- LW with mem_ready delayed 3 cycles in MEMRD → mem_req and AdrSrc = 1 held 4 cycles; RegWrite with ResultSrc = 01 one cycle later; total 8 cycles.
- BNE with Zero = 0 → PCWrite = 1 in BRANCH; repeat with Zero = 1 → PCWrite = 0; BGEU with LessU = 0 → PCWrite = 1.
- JALR → JALRADR, JAL (PCWrite = 1, PCMaskLSB = 1), ALUWB; following JAL instruction has PCMaskLSB = 0.
- op = 0000000 → illegal = 1, state TRAP; no enables for 10 cycles; rst clears. MEM_TIMEOUT = 16 with mem_ready stuck low in FETCH → bus_err at cycle 16.
- stall asserted in MEMWR with mem_ready = 1 → MemWrite = 0, state held; deassert → MemWrite pulse, then FETCH.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit:
// FSM states, opcode classes, datapath mux selects and ALU operations.
package cu_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR, S_EXECI,
    S_LUI, S_AUIPC, S_ALUWB, S_JALRADR, S_JAL, S_BRANCH, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    OC_LOAD, OC_STORE, OC_R, OC_I, OC_BRANCH, OC_JAL, OC_JALR, OC_LUI, OC_AUIPC, OC_NONE
  } op_class_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_ISH = 3'b001;
  localparam logic [2:0] IMM_S   = 3'b010;
  localparam logic [2:0] IMM_B   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_J   = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic op_class_t classify(input logic [6:0] op);
    case (op)
      OP_LOAD:   return OC_LOAD;
      OP_STORE:  return OC_STORE;
      OP_R:      return OC_R;
      OP_I:      return OC_I;
      OP_BRANCH: return OC_BRANCH;
      OP_JAL:    return OC_JAL;
      OP_JALR:   return OC_JALR;
      OP_LUI:    return OC_LUI;
      OP_AUIPC:  return OC_AUIPC;
      default:   return OC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of opcode class + funct fields into ALU operation,
// immediate format and an undefined-funct3 flag.
module alu_decoder
  import cu_pkg::*;
(
  input  op_class_t   op_class,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  output logic [3:0]  alu_ctrl,
  output logic [2:0]  imm_src,
  output logic        illegal_funct
);

  always_comb begin
    alu_ctrl      = ALU_ADD;
    imm_src       = IMM_I;
    illegal_funct = 1'b0;
    case (op_class)
      OC_R, OC_I: begin
        case (funct3)
          3'b000:  alu_ctrl = (op_class == OC_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
        if (op_class == OC_I && (funct3 == 3'b001 || funct3 == 3'b101))
          imm_src = IMM_ISH;
      end
      // Loads: only LB/LH/LW/LBU/LHU exist.
      OC_LOAD:   illegal_funct = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      OC_STORE: begin
        imm_src       = IMM_S;
        illegal_funct = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OC_BRANCH: begin
        imm_src       = IMM_B;
        alu_ctrl      = ALU_SUB;
        illegal_funct = (funct3[2:1] == 2'b01);
      end
      OC_JAL:            imm_src = IMM_J;
      OC_LUI, OC_AUIPC:  imm_src = IMM_U;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// against a shared memory with ready handshake, timeout, stall and sticky traps.
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       Zero,
  input  logic       Less,
  input  logic       LessU,
  input  logic       mem_ready,
  input  logic       stall,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       OldPCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUctrl,
  output logic [2:0] ImmSrc,
  output logic [1:0] ResultSrc,
  output logic       PCMaskLSB,
  output logic [2:0] funct3_o,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state_o
);

  // Keep the counter at least one bit wide when the timeout is disabled.
  localparam int CW = (TO_W < 1) ? 1 : TO_W;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            illegal_reg, bus_err_reg, jalr_flag_reg, jalr_flag_next;
  logic            set_illegal, set_bus_err;
  op_class_t       op_class;
  logic [3:0]      dec_alu_ctrl;
  logic [2:0]      dec_imm_src;
  logic            dec_illegal;
  logic            waiting, timeout, br_taken;

  assign op_class = classify(op);

  alu_decoder u_dec (
    .op_class      (op_class),
    .funct3        (funct3),
    .funct7_5      (funct7_5),
    .alu_ctrl      (dec_alu_ctrl),
    .imm_src       (dec_imm_src),
    .illegal_funct (dec_illegal)
  );

  assign waiting = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);
  assign timeout = (MEM_TIMEOUT > 0) && (cnt_reg == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    case (funct3)
      3'b000:  br_taken = Zero;
      3'b001:  br_taken = ~Zero;
      3'b100:  br_taken = Less;
      3'b101:  br_taken = ~Less;
      3'b110:  br_taken = LessU;
      3'b111:  br_taken = ~LessU;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_FETCH;
      cnt_reg       <= '0;
      illegal_reg   <= 1'b0;
      bus_err_reg   <= 1'b0;
      jalr_flag_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      illegal_reg   <= illegal_reg | set_illegal;
      bus_err_reg   <= bus_err_reg | set_bus_err;
      jalr_flag_reg <= jalr_flag_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    set_illegal    = 1'b0;
    set_bus_err    = 1'b0;
    jalr_flag_next = jalr_flag_reg;
    if (!stall) begin
      case (state_reg)
        S_FETCH:  if (mem_ready) state_next = S_DECODE;
        S_DECODE: begin
          case (op_class)
            OC_LOAD, OC_STORE: state_next = S_MEMADR;
            OC_R:              state_next = S_EXECR;
            OC_I:              state_next = S_EXECI;
            OC_JAL:            state_next = S_JAL;
            OC_JALR:           state_next = S_JALRADR;
            OC_LUI:            state_next = S_LUI;
            OC_AUIPC:          state_next = S_AUIPC;
            OC_BRANCH:         state_next = S_BRANCH;
            default:           state_next = S_TRAP;
          endcase
          if (op_class == OC_NONE || dec_illegal) begin
            state_next  = S_TRAP;
            set_illegal = 1'b1;
          end
        end
        S_MEMADR: state_next = (op_class == OC_STORE) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
        S_MEMWR:  if (mem_ready) state_next = S_FETCH;
        S_MEMWB, S_ALUWB, S_BRANCH: state_next = S_FETCH;
        S_EXECR, S_EXECI, S_LUI, S_AUIPC: state_next = S_ALUWB;
        S_JALRADR: begin
          state_next     = S_JAL;
          jalr_flag_next = 1'b1;
        end
        S_JAL: begin
          state_next     = S_ALUWB;
          jalr_flag_next = 1'b0;
        end
        default: state_next = S_TRAP;
      endcase
      // A ready arriving on the limit cycle wins over the timeout.
      if (waiting && !mem_ready && timeout) begin
        state_next  = S_TRAP;
        set_bus_err = 1'b1;
      end
      if (state_next != state_reg)
        cnt_next = '0;
      else if (waiting && !mem_ready)
        cnt_next = cnt_reg + CW'(1);
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    OldPCWrite = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    mem_req    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUctrl    = ALU_NOP;
    ImmSrc     = IMM_I;
    ResultSrc  = RES_ALUOUT;
    PCMaskLSB  = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req    = 1'b1;
        ALUSrcB    = SRCB_4;
        ALUctrl    = ALU_ADD;
        ResultSrc  = RES_ALURES;
        IRWrite    = mem_ready;
        OldPCWrite = mem_ready;
        PCWrite    = mem_ready;
      end
      S_DECODE:  begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; ALUctrl = ALU_ADD; ImmSrc = dec_imm_src; end
      S_MEMADR:  begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; ALUctrl = ALU_ADD; ImmSrc = dec_imm_src; end
      S_MEMRD:   begin AdrSrc = 1'b1; mem_req = 1'b1; end
      S_MEMWB:   begin ResultSrc = RES_DATA; RegWrite = 1'b1; end
      S_MEMWR:   begin AdrSrc = 1'b1; mem_req = 1'b1; MemWrite = 1'b1; end
      S_EXECR:   begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_RS2; ALUctrl = dec_alu_ctrl; end
      S_EXECI:   begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; ALUctrl = dec_alu_ctrl; ImmSrc = dec_imm_src; end
      S_LUI:     begin ALUSrcA = SRCA_ZERO; ALUSrcB = SRCB_IMM; ALUctrl = ALU_ADD; ImmSrc = IMM_U; end
      S_AUIPC:   begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; ALUctrl = ALU_ADD; ImmSrc = IMM_U; end
      S_ALUWB:   RegWrite = 1'b1;
      S_JALRADR: begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; ALUctrl = ALU_ADD; end
      S_JAL: begin
        PCWrite   = 1'b1;
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_4;
        ALUctrl   = ALU_ADD;
        PCMaskLSB = jalr_flag_reg;
      end
      S_BRANCH:  begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_RS2; ALUctrl = ALU_SUB; PCWrite = br_taken; end
      default: ;
    endcase
    // Freeze: no architectural state may change, but the bus request stays up.
    if (stall) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      OldPCWrite = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
    end
  end

  assign funct3_o = funct3;
  assign illegal  = illegal_reg;
  assign bus_err  = bus_err_reg;
  assign state_o  = state_reg;

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for multicycle_cu: walks each instruction class through the FSM
// and checks enables, selects, traps, wait-states and stall behaviour.
module tb_multicycle_cu;
  import cu_pkg::*;

  logic       clk = 1'b0;
  logic       rst, funct7_5, Zero, Less, LessU, mem_ready, stall;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       PCWrite, IRWrite, OldPCWrite, RegWrite, MemWrite, mem_req, AdrSrc, PCMaskLSB;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] ALUctrl, state_o;
  logic [2:0] ImmSrc, funct3_o;
  logic       illegal, bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_cu #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .Zero(Zero), .Less(Less), .LessU(LessU), .mem_ready(mem_ready), .stall(stall),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .OldPCWrite(OldPCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .mem_req(mem_req), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc),
    .PCMaskLSB(PCMaskLSB), .funct3_o(funct3_o), .illegal(illegal), .bus_err(bus_err),
    .state_o(state_o)
  );

  // Advance one clock; inputs change 1 time unit after the edge, checks 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; mem_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f75);
    op = o; funct3 = f3; funct7_5 = f75;
  endtask

  task automatic test_reset();
    op = OP_R; funct3 = 3'b000; funct7_5 = 1'b0; Zero = 1'b0; Less = 1'b0; LessU = 1'b0;
    mem_ready = 1'b0; stall = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (state_o !== 4'(S_FETCH)) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state_o, S_FETCH); end
    checks++; if ({mem_req, AdrSrc, IRWrite, PCWrite, illegal, bus_err} !== 6'b100000) begin errors++;
      $display("FAIL reset_outputs got req/adr/ir/pc/ill/berr=%b exp=100000", {mem_req, AdrSrc, IRWrite, PCWrite, illegal, bus_err}); end
    stall = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_rtype(input logic f75, input logic [3:0] exp_alu);
    set_instr(OP_R, 3'b000, f75); mem_ready = 1'b1;
    #1;
    checks++; if ({IRWrite, OldPCWrite, PCWrite, RegWrite, ResultSrc} !== 6'b111010) begin errors++;
      $display("FAIL r_fetch got ir/old/pc/rw/res=%b exp=111010", {IRWrite, OldPCWrite, PCWrite, RegWrite, ResultSrc}); end
    tick();
    checks++; if (state_o !== 4'(S_DECODE) || RegWrite !== 1'b0) begin errors++; $display("FAIL r_decode state=%0d rw=%b", state_o, RegWrite); end
    tick();
    checks++; if (state_o !== 4'(S_EXECR) || ALUctrl !== exp_alu || RegWrite !== 1'b0) begin errors++;
      $display("FAIL r_exec state=%0d alu=%b exp_alu=%b rw=%b", state_o, ALUctrl, exp_alu, RegWrite); end
    tick();
    checks++; if (state_o !== 4'(S_ALUWB) || RegWrite !== 1'b1 || ResultSrc !== 2'b00) begin errors++;
      $display("FAIL r_wb state=%0d rw=%b res=%b", state_o, RegWrite, ResultSrc); end
    tick();
    checks++; if (state_o !== 4'(S_FETCH)) begin errors++; $display("FAIL r_back state=%0d exp=%0d", state_o, S_FETCH); end
    $display("test_rtype f7_5=%0b alu=%b done", f75, exp_alu);
  endtask

  task automatic test_srai();
    set_instr(OP_I, 3'b101, 1'b1); mem_ready = 1'b1;
    tick(); tick();
    checks++; if (state_o !== 4'(S_EXECI) || ALUctrl !== 4'b0111 || ImmSrc !== 3'b001 || ALUSrcB !== 2'b01) begin errors++;
      $display("FAIL srai_exec state=%0d alu=%b imm=%b srcb=%b exp alu=0111 imm=001 srcb=01", state_o, ALUctrl, ImmSrc, ALUSrcB); end
    tick(); tick();
    $display("test_srai done");
  endtask

  task automatic test_load();
    set_instr(OP_LOAD, 3'b010, 1'b0); mem_ready = 1'b1;
    tick(); tick();
    checks++; if (state_o !== 4'(S_MEMADR) || ImmSrc !== 3'b000 || ALUSrcA !== 2'b10) begin errors++;
      $display("FAIL lw_memadr state=%0d imm=%b srca=%b", state_o, ImmSrc, ALUSrcA); end
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      checks++; if (state_o !== 4'(S_MEMRD) || mem_req !== 1'b1 || AdrSrc !== 1'b1 || RegWrite !== 1'b0) begin errors++;
        $display("FAIL lw_wait%0d state=%0d req=%b adr=%b rw=%b", i, state_o, mem_req, AdrSrc, RegWrite); end
      tick();
    end
    checks++; if (state_o !== 4'(S_MEMWB) || RegWrite !== 1'b1 || ResultSrc !== 2'b01) begin errors++;
      $display("FAIL lw_wb state=%0d rw=%b res=%b exp res=01", state_o, RegWrite, ResultSrc); end
    tick();
    checks++; if (state_o !== 4'(S_FETCH)) begin errors++; $display("FAIL lw_total state=%0d exp=%0d", state_o, S_FETCH); end
    $display("test_load done");
  endtask

  task automatic test_branch(input logic [2:0] f3, input logic z, input logic lu, input logic exp_pc);
    set_instr(OP_BRANCH, f3, 1'b0); Zero = z; Less = 1'b0; LessU = lu; mem_ready = 1'b1;
    tick(); tick();
    checks++; if (state_o !== 4'(S_BRANCH) || PCWrite !== exp_pc || ALUctrl !== 4'b0001) begin errors++;
      $display("FAIL br f3=%b state=%0d pcw=%b exp=%b alu=%b", f3, state_o, PCWrite, exp_pc, ALUctrl); end
    tick();
    checks++; if (state_o !== 4'(S_FETCH)) begin errors++; $display("FAIL br_back state=%0d", state_o); end
    $display("test_branch f3=%b zero=%b lessu=%b done", f3, z, lu);
  endtask

  task automatic test_jalr();
    set_instr(OP_JALR, 3'b000, 1'b0); mem_ready = 1'b1;
    tick(); tick();
    checks++; if (state_o !== 4'(S_JALRADR) || ALUSrcA !== 2'b10 || ALUSrcB !== 2'b01) begin errors++;
      $display("FAIL jalr_adr state=%0d srca=%b srcb=%b", state_o, ALUSrcA, ALUSrcB); end
    tick();
    checks++; if (state_o !== 4'(S_JAL) || PCWrite !== 1'b1 || PCMaskLSB !== 1'b1 || ALUSrcB !== 2'b10) begin errors++;
      $display("FAIL jalr_jal state=%0d pcw=%b mask=%b srcb=%b", state_o, PCWrite, PCMaskLSB, ALUSrcB); end
    tick();
    checks++; if (state_o !== 4'(S_ALUWB) || RegWrite !== 1'b1) begin errors++; $display("FAIL jalr_wb state=%0d rw=%b", state_o, RegWrite); end
    tick();
    set_instr(OP_JAL, 3'b000, 1'b0);
    tick(); tick();
    checks++; if (state_o !== 4'(S_JAL) || PCWrite !== 1'b1 || PCMaskLSB !== 1'b0) begin errors++;
      $display("FAIL jal state=%0d pcw=%b mask=%b exp mask=0", state_o, PCWrite, PCMaskLSB); end
    tick(); tick();
    $display("test_jalr done");
  endtask

  task automatic test_stall();
    set_instr(OP_STORE, 3'b010, 1'b0); mem_ready = 1'b1; stall = 1'b1;
    #1;
    checks++; if (IRWrite !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL stall_fetch ir=%b req=%b", IRWrite, mem_req); end
    tick();
    checks++; if (state_o !== 4'(S_FETCH)) begin errors++; $display("FAIL stall_fetch_hold state=%0d", state_o); end
    stall = 1'b0;
    tick(); tick();
    checks++; if (state_o !== 4'(S_MEMADR) || ImmSrc !== 3'b010) begin errors++; $display("FAIL sw_memadr state=%0d imm=%b", state_o, ImmSrc); end
    tick();
    stall = 1'b1;
    #1;
    checks++; if (state_o !== 4'(S_MEMWR) || MemWrite !== 1'b0 || mem_req !== 1'b1 || AdrSrc !== 1'b1) begin errors++;
      $display("FAIL sw_stalled state=%0d mw=%b req=%b adr=%b", state_o, MemWrite, mem_req, AdrSrc); end
    tick();
    stall = 1'b0;
    #1;
    checks++; if (state_o !== 4'(S_MEMWR) || MemWrite !== 1'b1) begin errors++; $display("FAIL sw_release state=%0d mw=%b", state_o, MemWrite); end
    tick();
    checks++; if (state_o !== 4'(S_FETCH)) begin errors++; $display("FAIL sw_back state=%0d", state_o); end
    $display("test_stall done");
  endtask

  task automatic test_illegal();
    set_instr(7'b0000000, 3'b000, 1'b0); mem_ready = 1'b1;
    tick(); tick();
    checks++; if (state_o !== 4'(S_TRAP) || illegal !== 1'b1 || bus_err !== 1'b0) begin errors++;
      $display("FAIL ill_trap state=%0d ill=%b berr=%b", state_o, illegal, bus_err); end
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      #1;
      checks++; if ({PCWrite, IRWrite, OldPCWrite, RegWrite, MemWrite, mem_req} !== 6'b0 || state_o !== 4'(S_TRAP)) begin errors++;
        $display("FAIL ill_quiet%0d en=%b state=%0d", i, {PCWrite, IRWrite, OldPCWrite, RegWrite, MemWrite, mem_req}, state_o); end
      tick();
    end
    do_reset();
    checks++; if (illegal !== 1'b0 || state_o !== 4'(S_FETCH)) begin errors++; $display("FAIL ill_clear ill=%b state=%0d", illegal, state_o); end
    set_instr(OP_BRANCH, 3'b010, 1'b0);
    tick(); tick();
    checks++; if (state_o !== 4'(S_TRAP) || illegal !== 1'b1) begin errors++; $display("FAIL ill_brf3 state=%0d ill=%b", state_o, illegal); end
    do_reset();
    $display("test_illegal done");
  endtask

  task automatic test_timeout();
    set_instr(OP_R, 3'b000, 1'b0);
    do_reset();
    mem_ready = 1'b0;
    repeat (15) tick();
    checks++; if (bus_err !== 1'b0 || state_o !== 4'(S_FETCH)) begin errors++; $display("FAIL to_before berr=%b state=%0d", bus_err, state_o); end
    tick();
    checks++; if (bus_err !== 1'b1 || state_o !== 4'(S_TRAP) || mem_req !== 1'b0) begin errors++;
      $display("FAIL to_trap berr=%b state=%0d req=%b", bus_err, state_o, mem_req); end
    do_reset();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_clear berr=%b", bus_err); end
    mem_ready = 1'b0;
    repeat (15) tick();
    mem_ready = 1'b1;
    tick();
    checks++; if (bus_err !== 1'b0 || state_o !== 4'(S_DECODE)) begin errors++;
      $display("FAIL to_ready_wins berr=%b state=%0d exp=%0d", bus_err, state_o, S_DECODE); end
    $display("test_timeout done");
  endtask

  initial begin
    test_reset();
    test_rtype(1'b0, 4'b0000);
    test_rtype(1'b1, 4'b0001);
    test_srai();
    test_load();
    test_branch(3'b001, 1'b0, 1'b0, 1'b1);
    test_branch(3'b001, 1'b1, 1'b0, 1'b0);
    test_branch(3'b111, 1'b0, 1'b0, 1'b1);
    test_jalr();
    test_stall();
    test_illegal();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
